// File: rtl/hvac_sequencer_if.sv
// Thermostat-to-sequencer bundle: temperatures and mode in, actuator drives and status out.
// Define HVAC_FAN_CONT_EN to add the fan_cont continuous-fan request.
`timescale 1ns/1ps
interface hvac_sequencer_if;
    logic [1:0] mode;
    logic [7:0] current;
    logic [7:0] desired;
`ifdef HVAC_FAN_CONT_EN
    logic       fan_cont;
`endif
    logic       heat_on;
    logic       cool_on;
    logic       fan_on;
    logic       fault;
    logic [2:0] state;

    modport master (
        output mode, current, desired,
`ifdef HVAC_FAN_CONT_EN
        output fan_cont,
`endif
        input  heat_on, cool_on, fan_on, fault, state
    );

    modport slave (
        input  mode, current, desired,
`ifdef HVAC_FAN_CONT_EN
        input  fan_cont,
`endif
        output heat_on, cool_on, fan_on, fault, state
    );
endinterface

// File: rtl/hvac_sequencer.sv
// HVAC heat/cool/fan sequencer with hysteresis, minimum run, fan purge and lockout; drives registered 1 edge after decision.
// No backpressure: inputs are sampled every slowclock1 edge. HVAC_FAN_CONT_EN adds the continuous-fan override.
`timescale 1ns/1ps
module hvac_sequencer #(
    parameter int HYST      = 2,
    parameter int MIN_RUN   = 8,
    parameter int FAN_PURGE = 3,
    parameter int MIN_OFF   = 4,
    parameter int TMAX      = 99
) (
    input  logic               slowclock1,
    input  logic               Reset,
    hvac_sequencer_if.slave    bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEAT    = 3'd1,
        S_COOL    = 3'd2,
        S_PURGE   = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    localparam logic [8:0] L_HYST    = 9'(HYST);
    localparam logic [7:0] L_TMAX    = 8'(TMAX);
    localparam logic [7:0] L_RUN_M1  = 8'(MIN_RUN - 1);
    localparam logic [7:0] L_PURG_M1 = 8'(FAN_PURGE - 1);
    localparam logic [7:0] L_OFF_M1  = 8'(MIN_OFF - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_timer;
    logic       r_heat, r_cool, r_fan, r_fault;
    logic       w_heat_d, w_cool_d, w_fan_d;
    logic       w_flt, w_heat_ok, w_cool_ok, w_run_done;
    logic [8:0] w_cur9, w_des9;

    assign w_cur9     = {1'b0, bus.current};
    assign w_des9     = {1'b0, bus.desired};
    assign w_flt      = (bus.current > L_TMAX) || (bus.desired > L_TMAX);
    assign w_heat_ok  = ((w_cur9 + L_HYST) < w_des9) && bus.mode[0] && !w_flt;
    assign w_cool_ok  = (w_cur9 > (w_des9 + L_HYST)) && bus.mode[1] && !w_flt;
    assign w_run_done = (r_timer >= L_RUN_M1);

    // Aborts (mode withdrawn or fault) bypass the minimum run time.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_heat_ok)
                    w_next = S_HEAT;
                else if (w_cool_ok)
                    w_next = S_COOL;
            end
            S_HEAT: begin
                if (!bus.mode[0] || w_flt || ((w_cur9 >= w_des9) && w_run_done))
                    w_next = S_PURGE;
            end
            S_COOL: begin
                if (!bus.mode[1] || w_flt || ((w_cur9 <= w_des9) && w_run_done))
                    w_next = S_PURGE;
            end
            S_PURGE: begin
                if (r_timer >= L_PURG_M1)
                    w_next = S_LOCKOUT;
            end
            S_LOCKOUT: begin
                if (r_timer >= L_OFF_M1)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_heat_d = (w_next == S_HEAT);
        w_cool_d = (w_next == S_COOL);
        w_fan_d  = (w_next == S_HEAT) || (w_next == S_COOL) || (w_next == S_PURGE);
`ifdef HVAC_FAN_CONT_EN
        if (bus.fan_cont)
            w_fan_d = 1'b1;
`endif
    end

    always_ff @(posedge slowclock1 or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_timer <= 8'd0;
            r_heat  <= 1'b0;
            r_cool  <= 1'b0;
            r_fan   <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_timer <= 8'd0;
            else if (r_timer != 8'hFF)
                r_timer <= r_timer + 8'd1;
            r_heat  <= w_heat_d;
            r_cool  <= w_cool_d;
            r_fan   <= w_fan_d;
            r_fault <= w_flt;
        end
    end

    assign bus.heat_on = r_heat;
    assign bus.cool_on = r_cool;
    assign bus.fan_on  = r_fan;
    assign bus.fault   = r_fault;
    assign bus.state   = r_state;
endmodule

// File: tb/tb_hvac_sequencer.sv
// Directed bench for hvac_sequencer: heat cycle, cool entry, aborts, lockout, fault and async reset.
`timescale 1ns/1ps
module tb_hvac_sequencer;
    logic slowclock1;
    logic Reset;
    int   n_checks;
    int   n_pass;
    int   len;
    logic [6:0] got;
    logic [6:0] exp;

    hvac_sequencer_if bus ();

    hvac_sequencer dut (
        .slowclock1 (slowclock1),
        .Reset      (Reset),
        .bus        (bus)
    );

    initial slowclock1 = 1'b0;
    always #5 slowclock1 = ~slowclock1;

    // {state, heat_on, cool_on, fan_on, fault}
    function automatic logic [6:0] pack();
        return {bus.state, bus.heat_on, bus.cool_on, bus.fan_on, bus.fault};
    endfunction

    task automatic step();
        @(posedge slowclock1);
        #1;
    endtask

    task automatic run_len(input logic [2:0] st, output int n);
        n = 0;
        while (bus.state == st && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.mode = 2'b11;
        bus.desired = 8'd72;
        bus.current = 8'd72;
`ifdef HVAC_FAN_CONT_EN
        bus.fan_cont = 1'b0;
`endif
        #2;
        got = pack(); exp = 7'b000_0000; n_checks++;
        if (got !== exp) $display("FAIL reset_state: got %b expected %b", got, exp); else n_pass++;
        @(negedge slowclock1);
        Reset = 1'b0;
        step();
        got = pack(); exp = 7'b000_0000; n_checks++;
        if (got !== exp) $display("FAIL idle_after_reset: got %b expected %b", got, exp); else n_pass++;
    endtask

    task automatic test_heat_cycle();
        bus.current = 8'd69;
        step();
        got = pack(); exp = {3'd1, 4'b1010}; n_checks++;
        if (got !== exp) $display("FAIL heat_enter: got %b expected %b", got, exp); else n_pass++;
        step();
        step();
        bus.current = 8'd72;
        run_len(3'd1, len);
        n_checks++;
        if (len + 2 !== 8) $display("FAIL heat_min_run: got %0d cycles expected 8", len + 2); else n_pass++;
        got = pack(); exp = {3'd3, 4'b0010}; n_checks++;
        if (got !== exp) $display("FAIL purge_outputs: got %b expected %b", got, exp); else n_pass++;
        run_len(3'd3, len);
        n_checks++;
        if (len !== 3) $display("FAIL purge_len: got %0d expected 3", len); else n_pass++;
        got = pack(); exp = {3'd4, 4'b0000}; n_checks++;
        if (got !== exp) $display("FAIL lockout_outputs: got %b expected %b", got, exp); else n_pass++;
        run_len(3'd4, len);
        n_checks++;
        if (len !== 4) $display("FAIL lockout_len: got %0d expected 4", len); else n_pass++;
        got = pack(); exp = {3'd0, 4'b0000}; n_checks++;
        if (got !== exp) $display("FAIL idle_after_cycle: got %b expected %b", got, exp); else n_pass++;
    endtask

    task automatic test_mode_gate();
        bus.mode = 2'b10;
        bus.current = 8'd60;
        step();
        step();
        got = pack(); exp = 7'b000_0000; n_checks++;
        if (got !== exp) $display("FAIL heat_in_cool_only: got %b expected %b", got, exp); else n_pass++;
        bus.mode = 2'b01;
        bus.current = 8'd80;
        step();
        got = pack(); exp = 7'b000_0000; n_checks++;
        if (got !== exp) $display("FAIL cool_in_heat_only: got %b expected %b", got, exp); else n_pass++;
        bus.mode = 2'b00;
        bus.current = 8'd60;
        step();
        got = pack(); exp = 7'b000_0000; n_checks++;
        if (got !== exp) $display("FAIL mode_off: got %b expected %b", got, exp); else n_pass++;
        bus.mode = 2'b11;
    endtask

    task automatic test_cool_entry();
        bus.desired = 8'd72;
        bus.current = 8'd74;
        step();
        step();
        got = pack(); exp = 7'b000_0000; n_checks++;
        if (got !== exp) $display("FAIL hyst_edge_idle: got %b expected %b", got, exp); else n_pass++;
        bus.current = 8'd75;
        step();
        got = pack(); exp = {3'd2, 4'b0110}; n_checks++;
        if (got !== exp) $display("FAIL cool_enter: got %b expected %b", got, exp); else n_pass++;
    endtask

    task automatic test_abort_lockout();
        step();
        got = pack(); exp = {3'd2, 4'b0110}; n_checks++;
        if (got !== exp) $display("FAIL cool_hold: got %b expected %b", got, exp); else n_pass++;
        bus.mode = 2'b01;
        step();
        got = pack(); exp = {3'd3, 4'b0010}; n_checks++;
        if (got !== exp) $display("FAIL cool_abort: got %b expected %b", got, exp); else n_pass++;
        bus.mode = 2'b11;
        bus.current = 8'd60;
        run_len(3'd3, len);
        n_checks++;
        if (len !== 3) $display("FAIL abort_purge_len: got %0d expected 3", len); else n_pass++;
        run_len(3'd4, len);
        n_checks++;
        if (len !== 4) $display("FAIL lockout_demand_len: got %0d expected 4", len); else n_pass++;
        got = pack(); exp = 7'b000_0000; n_checks++;
        if (got !== exp) $display("FAIL idle_between: got %b expected %b", got, exp); else n_pass++;
        step();
        got = pack(); exp = {3'd1, 4'b1010}; n_checks++;
        if (got !== exp) $display("FAIL heat_after_lockout: got %b expected %b", got, exp); else n_pass++;
    endtask

    task automatic test_fault();
        bus.current = 8'd100;
        step();
        got = pack(); exp = {3'd3, 4'b0011}; n_checks++;
        if (got !== exp) $display("FAIL fault_abort: got %b expected %b", got, exp); else n_pass++;
        run_len(3'd3, len);
        run_len(3'd4, len);
        n_checks++;
        if (len !== 4) $display("FAIL fault_lockout_len: got %0d expected 4", len); else n_pass++;
        step();
        step();
        got = pack(); exp = {3'd0, 4'b0001}; n_checks++;
        if (got !== exp) $display("FAIL fault_blocks_entry: got %b expected %b", got, exp); else n_pass++;
        bus.current = 8'd60;
        step();
        got = pack(); exp = {3'd1, 4'b1010}; n_checks++;
        if (got !== exp) $display("FAIL fault_clear_heat: got %b expected %b", got, exp); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        step();
        #3;
        Reset = 1'b1;
        #1;
        got = pack(); exp = 7'b000_0000; n_checks++;
        if (got !== exp) $display("FAIL async_reset: got %b expected %b", got, exp); else n_pass++;
`ifdef HVAC_FAN_CONT_EN
        bus.fan_cont = 1'b1;
        bus.mode = 2'b00;
        exp = {3'd0, 4'b0010};
`else
        exp = {3'd1, 4'b1010};
`endif
        @(negedge slowclock1);
        Reset = 1'b0;
        step();
        got = pack(); n_checks++;
        if (got !== exp) $display("FAIL after_release: got %b expected %b", got, exp); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        test_reset();
        test_heat_cycle();
        test_mode_gate();
        test_cool_entry();
        test_abort_lockout();
        test_fault();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
